arith_result_collector: RTL

//  Downstream stage of the add/mul/sub arithmetic units. Tracks each issued operation, captures
//  the unit result one cycle after issue, normalises it to a common 9-bit signed word, tags it,
//  and queues it in a FIFO drained through a valid/ready handshake. Gates new issues via credit.

---
 rtl/arith_result_collector_pkg.sv | 42 ++++
 rtl/arith_result_collector_if.sv | 37 +++
 rtl/arith_result_collector_sync_fifo.sv | 52 +++++
 rtl/arith_result_collector.sv | 79 +++++++
 4 files changed

// File: rtl/arith_result_collector_pkg.sv
// Shared op codes, widths, result entry type and the result normaliser for the collector.
// Pure types and a combinational function: no latency, no flow control.
package arith_result_collector_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2,
    OP_ILL = 2'd3
  } op_e;

  localparam int ADD_W = 5;
  localparam int MUL_W = 8;
  localparam int SUB_W = 5;
  localparam int RES_W = 9;
  localparam int TAG_W = 4;

  typedef struct packed {
    op_e                     op;
    logic [TAG_W-1:0]        tag;
    logic signed [RES_W-1:0] data;
  } res_t;

  // Adder and multiplier results are unsigned; the subtractor result is sign-extended.
  function automatic logic signed [RES_W-1:0] normalise(
    input op_e              op,
    input logic [ADD_W-1:0] add_val,
    input logic [MUL_W-1:0] mul_val,
    input logic [SUB_W-1:0] sub_val
  );
    logic signed [RES_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {{(RES_W-ADD_W){1'b0}}, add_val};
      OP_MUL:  r = {{(RES_W-MUL_W){1'b0}}, mul_val};
      OP_SUB:  r = {{(RES_W-SUB_W){sub_val[SUB_W-1]}}, sub_val};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arith_result_collector_if.sv
// Issue, unit-result and result-drain signals of the collector bundled as one interface.
// The collector takes the slave side; the issuing/consuming environment takes the master side.
interface arith_result_collector_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 3
);
  import arith_result_collector_pkg::*;

  logic             iss_valid;
  logic             iss_ready;
  logic [1:0]       iss_op;
  logic [TAG_W-1:0] iss_tag;

  logic [ADD_W-1:0] add_out;
  logic [MUL_W-1:0] mul_out;
  logic [SUB_W-1:0] sub_out;

  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_op;
  logic [TAG_W-1:0] res_tag;
  logic [RES_W-1:0] res_data;

  logic [CNT_W-1:0] fifo_count;
  logic             err_illegal;

  modport slave (
    input  iss_valid, iss_op, iss_tag, add_out, mul_out, sub_out, res_ready,
    output iss_ready, res_valid, res_op, res_tag, res_data, fifo_count, err_illegal
  );

  modport master (
    output iss_valid, iss_op, iss_tag, add_out, mul_out, sub_out, res_ready,
    input  iss_ready, res_valid, res_op, res_tag, res_data, fifo_count, err_illegal
  );

endinterface

// File: rtl/arith_result_collector_sync_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH; a push shows at the head one cycle later (no bypass).
// Push on full and pop on empty are ignored; pointers wrap modulo DEPTH (power of 2).
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/arith_result_collector.sv
// Captures add/mul/sub unit results one cycle after issue, normalises and tags them into a FIFO.
// Issue-to-res_valid is 2 cycles; iss_ready is credit from registered count+pending only (no res_ready path).
module arith_result_collector #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  arith_result_collector_if.slave bus
);
  import arith_result_collector_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = 2 + TAG_W + RES_W;

  logic             pend_v;
  op_e              pend_op;
  logic [TAG_W-1:0] pend_tag;

  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   committed;
  logic [ENT_W-1:0] push_ent;
  logic [ENT_W-1:0] head_ent;

  // A pending issue holds a slot even when it turns out illegal, so a push can never hit a full FIFO.
  assign committed     = {1'b0, count} + {{CNT_W{1'b0}}, pend_v};
  assign bus.iss_ready = !rst && (committed < (CNT_W+1)'(DEPTH));
  assign accept        = bus.iss_valid && bus.iss_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v   <= 1'b0;
      pend_op  <= OP_ADD;
      pend_tag <= '0;
    end else begin
      pend_v <= accept;
      if (accept) begin
        pend_op  <= op_e'(bus.iss_op);
        pend_tag <= bus.iss_tag;
      end
    end
  end

  assign push     = pend_v && (pend_op != OP_ILL);
  assign push_ent = {pend_op, pend_tag,
                     normalise(pend_op, bus.add_out, bus.mul_out, bus.sub_out)};
  assign pop      = bus.res_valid && bus.res_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head_ent),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Head fields read as zero whenever nothing is queued.
  assign bus.res_valid  = !empty;
  assign bus.res_op     = empty ? 2'b00 : head_ent[ENT_W-1 -: 2];
  assign bus.res_tag    = empty ? '0 : head_ent[RES_W +: TAG_W];
  assign bus.res_data   = empty ? '0 : head_ent[RES_W-1:0];
  assign bus.fifo_count = count;
  assign bus.err_illegal = !rst && pend_v && (pend_op == OP_ILL);

  a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
